// File: rtl/uart_cmd_wrapper.sv
// uart_cmd_wrapper
//   Robot-side byte endpoint of the Bluetooth UART link.
//   RX path: pairs received bytes (high byte first) into a 16-bit command for
//   cmd_proc, with a level ready flag and an overrun pulse.
//   TX path: serialises 8-bit responses to UART_tx with a one-deep pending
//   slot; a third response while busy and the slot is full is dropped.
//
// Ports
//   clk, rst           system clock, synchronous active-high reset
//   rx_rdy, rx_data    received-byte strobe and data from UART_rx
//   cmd, cmd_rdy       assembled command and its valid level
//   clr_cmd_rdy        consumer clears cmd_rdy
//   cmd_ovr            pulse: a command completed while cmd_rdy was still set
//   send_resp, resp    response request and byte from cmd_proc
//   tx_trmt, tx_data   start pulse and byte to UART_tx
//   tx_done            byte-complete strobe from UART_tx
//   resp_sent          pulse one clock after tx_done
//   resp_drop          pulse: response lost (busy, slot full)
//
// Optional feature macro: CMD_TIMEOUT_EN
//   When defined, a partial command (high byte only) is abandoned after
//   TIMEOUT_CLKS clocks in LOW without a byte.
module uart_cmd_wrapper #(
  parameter logic [19:0] TIMEOUT_CLKS = 20'd1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        cmd_ovr,
  input  logic        send_resp,
  input  logic [7:0]  resp,
  output logic        tx_trmt,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  output logic        resp_sent,
  output logic        resp_drop
);

  typedef enum logic {HIGH = 1'b0, LOW = 1'b1} rx_state_t;
  typedef enum logic {TX_IDLE = 1'b0, TX_BUSY = 1'b1} tx_state_t;

  rx_state_t r_rx_state, w_rx_next;
  tx_state_t r_tx_state, w_tx_next;

  logic [7:0] r_hi_byte;
  logic       r_pend_vld;
  logic [7:0] r_pend_byte;
  logic       w_timeout;

`ifdef CMD_TIMEOUT_EN
  logic [19:0] r_to_cnt;

  // Counts clocks spent waiting for the low byte; restarts on every byte.
  always_ff @(posedge clk) begin
    if (rst || r_rx_state != LOW || rx_rdy) r_to_cnt <= 20'd0;
    else                                    r_to_cnt <= r_to_cnt + 20'd1;
  end

  assign w_timeout = (r_rx_state == LOW) && (r_to_cnt == TIMEOUT_CLKS - 20'd1);
`else
  logic [19:0] w_unused_to;
  assign w_unused_to = TIMEOUT_CLKS;
  assign w_timeout   = 1'b0;
`endif

  // ---------------- RX FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) r_rx_state <= HIGH;
    else     r_rx_state <= w_rx_next;
  end

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      HIGH:    if (rx_rdy) w_rx_next = LOW;
      LOW:     if (rx_rdy || w_timeout) w_rx_next = HIGH;
      default: w_rx_next = HIGH;
    endcase
  end

  logic w_load_hi, w_done_lo, w_load_cmd, w_ovr;

  // A clear in the completion cycle frees the slot, so the new command wins.
  always_comb begin
    w_load_hi  = (r_rx_state == HIGH) && rx_rdy;
    w_done_lo  = (r_rx_state == LOW) && rx_rdy;
    w_load_cmd = w_done_lo && (!cmd_rdy || clr_cmd_rdy);
    w_ovr      = w_done_lo && cmd_rdy && !clr_cmd_rdy;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi_byte <= 8'h00;
      cmd       <= 16'h0000;
      cmd_rdy   <= 1'b0;
      cmd_ovr   <= 1'b0;
    end else begin
      if (w_load_hi) r_hi_byte <= rx_data;
      if (w_load_cmd)       cmd <= {r_hi_byte, rx_data};
      if (w_load_cmd)       cmd_rdy <= 1'b1;
      else if (clr_cmd_rdy) cmd_rdy <= 1'b0;
      cmd_ovr <= w_ovr;
    end
  end

  // ---------------- TX FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) r_tx_state <= TX_IDLE;
    else     r_tx_state <= w_tx_next;
  end

  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      TX_IDLE: if (r_pend_vld || send_resp) w_tx_next = TX_BUSY;
      TX_BUSY: if (tx_done) w_tx_next = TX_IDLE;
      default: w_tx_next = TX_IDLE;
    endcase
  end

  logic       w_launch, w_pend_set, w_pend_clr, w_drop, w_sent;
  logic [7:0] w_launch_byte;

  // The pending byte always launches before a fresh request to keep order;
  // a request arriving in that same cycle takes over the freed slot.
  always_comb begin
    w_launch      = (r_tx_state == TX_IDLE) && (r_pend_vld || send_resp);
    w_launch_byte = r_pend_vld ? r_pend_byte : resp;
    w_pend_set    = send_resp && (((r_tx_state == TX_BUSY) && !r_pend_vld) ||
                                  ((r_tx_state == TX_IDLE) && r_pend_vld));
    w_pend_clr    = (r_tx_state == TX_IDLE) && r_pend_vld && !send_resp;
    w_drop        = (r_tx_state == TX_BUSY) && send_resp && r_pend_vld;
    w_sent        = (r_tx_state == TX_BUSY) && tx_done;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_vld  <= 1'b0;
      r_pend_byte <= 8'h00;
      tx_trmt     <= 1'b0;
      tx_data     <= 8'h00;
      resp_sent   <= 1'b0;
      resp_drop   <= 1'b0;
    end else begin
      if (w_pend_set)      r_pend_vld <= 1'b1;
      else if (w_pend_clr) r_pend_vld <= 1'b0;
      if (w_pend_set)      r_pend_byte <= resp;
      if (w_launch)        tx_data <= w_launch_byte;
      tx_trmt   <= w_launch;
      resp_sent <= w_sent;
      resp_drop <= w_drop;
    end
  end

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
module tb_uart_cmd_wrapper;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic        cmd_ovr;
  logic        send_resp = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        tx_trmt;
  logic [7:0]  tx_data;
  logic        tx_done = 1'b0;
  logic        resp_sent;
  logic        resp_drop;

  int checks = 0;
  int failures = 0;

  uart_cmd_wrapper #(.TIMEOUT_CLKS(20'd100)) dut (
    .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data), .cmd(cmd),
    .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .cmd_ovr(cmd_ovr),
    .send_resp(send_resp), .resp(resp), .tx_trmt(tx_trmt), .tx_data(tx_data),
    .tx_done(tx_done), .resp_sent(resp_sent), .resp_drop(resp_drop)
  );

  always #5 clk = ~clk;

  localparam logic N = 1'b0;
  localparam logic Y = 1'b1;

  typedef struct {
    logic rst, rx; logic [7:0] rxd; logic clr, snd; logic [7:0] rsp; logic dn;
    logic [15:0] e_cmd; logic e_rdy, e_ovr, e_trmt; logic [7:0] e_txd;
    logic e_sent, e_drop;
  } vec_t;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, sample 1 ns after the edge.
  task automatic step(input logic r, input logic rx, input logic [7:0] d,
                      input logic c, input logic s, input logic [7:0] rs,
                      input logic dn);
    rst = r; rx_rdy = rx; rx_data = d; clr_cmd_rdy = c;
    send_resp = s; resp = rs; tx_done = dn;
    @(posedge clk); #1;
    rst = 1'b0; rx_rdy = 1'b0; clr_cmd_rdy = 1'b0; send_resp = 1'b0; tx_done = 1'b0;
  endtask

  task automatic idle(); step(N, N, 8'h00, N, N, 8'h00, N); endtask

  vec_t vecs[19];
  int   hit;

  initial begin
    //           rst rx rxd   clr snd rsp   dn  cmd       rdy ovr trmt txd   sent drop
    vecs[0]  = '{Y, N, 8'h00, N, N, 8'h00, N, 16'h0000, N, N, N, 8'h00, N, N};
    vecs[1]  = '{N, Y, 8'h2F, N, N, 8'h00, N, 16'h0000, N, N, N, 8'h00, N, N};
    vecs[2]  = '{N, Y, 8'hF3, N, N, 8'h00, N, 16'h2FF3, Y, N, N, 8'h00, N, N};
    vecs[3]  = '{N, Y, 8'h40, N, N, 8'h00, N, 16'h2FF3, Y, N, N, 8'h00, N, N};
    vecs[4]  = '{N, Y, 8'h21, N, N, 8'h00, N, 16'h2FF3, Y, Y, N, 8'h00, N, N};
    vecs[5]  = '{N, N, 8'h00, N, N, 8'h00, N, 16'h2FF3, Y, N, N, 8'h00, N, N};
    vecs[6]  = '{N, Y, 8'h40, N, N, 8'h00, N, 16'h2FF3, Y, N, N, 8'h00, N, N};
    vecs[7]  = '{N, Y, 8'h21, Y, N, 8'h00, N, 16'h4021, Y, N, N, 8'h00, N, N};
    vecs[8]  = '{N, N, 8'h00, Y, N, 8'h00, N, 16'h4021, N, N, N, 8'h00, N, N};
    vecs[9]  = '{N, N, 8'h00, N, Y, 8'hA5, N, 16'h4021, N, N, Y, 8'hA5, N, N};
    vecs[10] = '{N, N, 8'h00, N, N, 8'h00, N, 16'h4021, N, N, N, 8'hA5, N, N};
    vecs[11] = '{N, N, 8'h00, N, Y, 8'h5A, N, 16'h4021, N, N, N, 8'hA5, N, N};
    vecs[12] = '{N, N, 8'h00, N, Y, 8'h11, N, 16'h4021, N, N, N, 8'hA5, N, Y};
    vecs[13] = '{N, N, 8'h00, N, N, 8'h00, N, 16'h4021, N, N, N, 8'hA5, N, N};
    vecs[14] = '{N, N, 8'h00, N, N, 8'h00, Y, 16'h4021, N, N, N, 8'hA5, Y, N};
    vecs[15] = '{N, N, 8'h00, N, N, 8'h00, N, 16'h4021, N, N, Y, 8'h5A, N, N};
    vecs[16] = '{N, N, 8'h00, N, N, 8'h00, N, 16'h4021, N, N, N, 8'h5A, N, N};
    vecs[17] = '{N, N, 8'h00, N, N, 8'h00, Y, 16'h4021, N, N, N, 8'h5A, Y, N};
    vecs[18] = '{N, N, 8'h00, N, N, 8'h00, N, 16'h4021, N, N, N, 8'h5A, N, N};

    @(posedge clk); #1;
    for (int i = 0; i < 19; i++) begin
      step(vecs[i].rst, vecs[i].rx, vecs[i].rxd, vecs[i].clr, vecs[i].snd,
           vecs[i].rsp, vecs[i].dn);
      chk($sformatf("v%0d cmd", i),       cmd,               vecs[i].e_cmd);
      chk($sformatf("v%0d cmd_rdy", i),   {15'd0, cmd_rdy},  {15'd0, vecs[i].e_rdy});
      chk($sformatf("v%0d cmd_ovr", i),   {15'd0, cmd_ovr},  {15'd0, vecs[i].e_ovr});
      chk($sformatf("v%0d tx_trmt", i),   {15'd0, tx_trmt},  {15'd0, vecs[i].e_trmt});
      chk($sformatf("v%0d tx_data", i),   {8'd0, tx_data},   {8'd0, vecs[i].e_txd});
      chk($sformatf("v%0d resp_sent", i), {15'd0, resp_sent},{15'd0, vecs[i].e_sent});
      chk($sformatf("v%0d resp_drop", i), {15'd0, resp_drop},{15'd0, vecs[i].e_drop});
    end

    // Long transmission: tx_done 500 clocks after launch.
    step(N, N, 8'h00, N, Y, 8'hA5, N);
    chk("long trmt", {15'd0, tx_trmt}, 16'd1);
    chk("long data", {8'd0, tx_data}, 16'h00A5);
    hit = 0;
    for (int i = 0; i < 499; i++) begin
      idle();
      if (tx_trmt || resp_sent) hit++;
    end
    chk("long quiet", hit[15:0], 16'd0);
    step(N, N, 8'h00, N, N, 8'h00, Y);
    chk("long sent", {15'd0, resp_sent}, 16'd1);
    idle();
    chk("long sent clr", {15'd0, resp_sent}, 16'd0);

    // send_resp coincident with tx_done goes to the slot, launches next cycle.
    step(N, N, 8'h00, N, Y, 8'h33, N);
    chk("co trmt1", {15'd0, tx_trmt}, 16'd1);
    step(N, N, 8'h00, N, Y, 8'h44, Y);
    chk("co sent", {15'd0, resp_sent}, 16'd1);
    chk("co trmt0", {15'd0, tx_trmt}, 16'd0);
    chk("co drop0", {15'd0, resp_drop}, 16'd0);
    idle();
    chk("co trmt2", {15'd0, tx_trmt}, 16'd1);
    chk("co data", {8'd0, tx_data}, 16'h0044);
    step(N, N, 8'h00, N, N, 8'h00, Y);
    idle();

    // Reset with a partial high byte, a byte in flight and one pending.
    step(N, Y, 8'h12, N, Y, 8'h77, N);
    step(N, N, 8'h00, N, Y, 8'h88, N);
    step(Y, N, 8'h00, N, N, 8'h00, N);
    chk("rst cmd", cmd, 16'h0000);
    chk("rst rdy", {15'd0, cmd_rdy}, 16'd0);
    chk("rst ovr", {15'd0, cmd_ovr}, 16'd0);
    chk("rst trmt", {15'd0, tx_trmt}, 16'd0);
    chk("rst data", {8'd0, tx_data}, 16'h0000);
    chk("rst drop", {15'd0, resp_drop}, 16'd0);
    step(N, N, 8'h00, N, N, 8'h00, Y);
    idle();
    chk("stray done", {15'd0, resp_sent}, 16'd0);
    chk("no pend launch", {15'd0, tx_trmt}, 16'd0);
    step(N, Y, 8'h9A, N, N, 8'h00, N);
    step(N, Y, 8'hBC, N, N, 8'h00, N);
    chk("post rst cmd", cmd, 16'h9ABC);
    chk("post rst rdy", {15'd0, cmd_rdy}, 16'd1);
    step(N, N, 8'h00, Y, N, 8'h00, N);

`ifdef CMD_TIMEOUT_EN
    step(N, Y, 8'h12, N, N, 8'h00, N);
    for (int i = 0; i < 100; i++) idle();
    step(N, Y, 8'h34, N, N, 8'h00, N);
    step(N, Y, 8'h56, N, N, 8'h00, N);
    chk("timeout cmd", cmd, 16'h3456);
    chk("timeout rdy", {15'd0, cmd_rdy}, 16'd1);
    chk("timeout ovr", {15'd0, cmd_ovr}, 16'd0);
`else
    // Without the timeout a lone byte stays pending as the high byte.
    step(N, Y, 8'h12, N, N, 8'h00, N);
    for (int i = 0; i < 100; i++) idle();
    step(N, Y, 8'h34, N, N, 8'h00, N);
    chk("no-timeout cmd", cmd, 16'h1234);
    chk("no-timeout rdy", {15'd0, cmd_rdy}, 16'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
